uart_tx: RTL and testbench

Serial transmitter that sits directly upstream of the team's UART receiver. It accepts one parallel byte with a valid strobe and drives the serial line: start bit, 8 data bits MSB first, optional parity, stop bit. Each bit lasts `prescale` clock cycles. Its `TX_OUT` is wire-compatible with the receiver's `RX_IN`, so the two blocks form a loopback pair for system test.

---
 rtl/uart_tx.sv | 162 ++++++++++++++++
 tb/tb_uart_tx.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: parallel-to-serial UART transmitter.
// Frame is start(0), data MSB first, optional parity, stop(1); each bit lasts
// `prescale` clocks. TX_OUT and busy are registered and idle high / low.
module uart_tx #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      TX_OUT,
  output logic                      busy
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned PS_W  = PRESCALE_WIDTH;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e                state_q,  state_d;
  logic [DATA_WIDTH-1:0] data_q,   data_d;
  logic                  par_en_q, par_en_d;
  logic                  parity_q, parity_d;
  logic [PS_W-1:0]       ps_q,     ps_d;
  logic [PS_W-1:0]       cnt_q,    cnt_d;
  logic [IDX_W-1:0]      idx_q,    idx_d;
  logic                  tx_q,     tx_d;
  logic                  busy_q,   busy_d;
  logic                  bit_end_c;

  // Last cycle of the current bit slot; ps_q is never 0 once a frame is accepted.
  assign bit_end_c = (cnt_q == (ps_q - PS_W'(1)));

  // Next-state and next-output logic; tx/busy are computed one cycle ahead so they leave flops.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    par_en_d = par_en_q;
    parity_d = parity_q;
    ps_d     = ps_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    tx_d     = tx_q;
    busy_d   = busy_q;

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        cnt_d  = '0;
        if (DATA_VALID) begin
          data_d   = P_DATA;
          par_en_d = PAR_EN;
          parity_d = PAR_TYP ? ~^P_DATA : ^P_DATA;
          ps_d     = (prescale == '0) ? PS_W'(1) : prescale;
          idx_d    = IDX_MSB;
          state_d  = S_START;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
        end
      end

      S_START: begin
        if (bit_end_c) begin
          cnt_d   = '0;
          state_d = S_DATA;
          tx_d    = data_q[idx_q];
        end else begin
          cnt_d = cnt_q + PS_W'(1);
        end
      end

      S_DATA: begin
        if (bit_end_c) begin
          cnt_d = '0;
          if (idx_q == '0) begin
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_q - IDX_W'(1);
            tx_d  = data_q[idx_q - IDX_W'(1)];
          end
        end else begin
          cnt_d = cnt_q + PS_W'(1);
        end
      end

      S_PARITY: begin
        if (bit_end_c) begin
          cnt_d   = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + PS_W'(1);
        end
      end

      S_STOP: begin
        if (bit_end_c) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + PS_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      par_en_q <= 1'b0;
      parity_q <= 1'b0;
      ps_q     <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      par_en_q <= par_en_d;
      parity_q <= parity_d;
      ps_q     <= ps_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: scoreboard of expected frames checked bit-slot by
// bit-slot on the serial line, plus a mid-bit sampling receiver model.
module tb_uart_tx;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 6;

  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        pt;
    int unsigned ps;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          DATA_VALID = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [PW-1:0] prescale = '0;
  logic          TX_OUT;
  logic          busy;

  uart_tx #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .prescale   (prescale),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];
  int          frames_done = 0;
  int unsigned last_end = 0;
  int unsigned last_len = 0;
  int unsigned last_gap = 0;
  logic [7:0]  last_rx = '0;
  logic        last_par_err = 1'b0;
  logic        last_stp_err = 1'b0;
  logic        prev_busy = 1'b0;

  // Checks one frame starting at the current sample (first start-bit cycle).
  task automatic check_frame();
    exp_t        e;
    int unsigned eff;
    int unsigned start;
    int          nslots;
    logic        exp_bits [0:10];
    logic        rx_bits  [0:10];
    logic        ok;
    logic        aborted;
    logic        obs_tx;
    logic        obs_busy;
    logic [7:0]  rx_byte;
    start    = cyc;
    last_gap = start - last_end;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_frame: busy=%b with empty scoreboard, required busy=0", busy);
      return;
    end
    e   = exp_q.pop_front();
    eff = (e.ps == 0) ? 1 : e.ps;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[1+i] = e.data[7-i];
    nslots = 9;
    if (e.pe) begin
      exp_bits[9] = e.pt ? ~^e.data : ^e.data;
      nslots = 10;
    end
    exp_bits[nslots] = 1'b1;
    nslots++;
    for (int i = 0; i < 11; i++) rx_bits[i] = 1'b0;
    aborted = 1'b0;
    for (int s = 0; s < nslots; s++) begin
      ok = 1'b1;
      obs_tx = exp_bits[s];
      obs_busy = 1'b1;
      for (int c = 0; c < int'(eff); c++) begin
        if (s != 0 || c != 0) @(negedge clk);
        if (rst_n !== 1'b1) begin
          aborted = 1'b1;
          break;
        end
        if ((TX_OUT !== exp_bits[s] || busy !== 1'b1) && ok) begin
          ok = 1'b0;
          obs_tx = TX_OUT;
          obs_busy = busy;
        end
        if (c == int'(eff / 2)) rx_bits[s] = TX_OUT;
      end
      if (aborted) break;
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL slot%0d data=%h: got tx=%b busy=%b, expected tx=%b busy=1",
                 s, e.data, obs_tx, obs_busy, exp_bits[s]);
      end
    end
    if (aborted) return;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || TX_OUT !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_end data=%h: got tx=%b busy=%b, expected tx=1 busy=0", e.data, TX_OUT, busy);
    end
    last_end = cyc;
    last_len = last_end - start;
    for (int i = 0; i < 8; i++) rx_byte[7-i] = rx_bits[1+i];
    last_rx      = rx_byte;
    last_par_err = e.pe && (rx_bits[9] !== (e.pt ? ~^rx_byte : ^rx_byte));
    last_stp_err = (rx_bits[nslots-1] !== 1'b1);
    frames_done++;
  endtask

  // Scoreboard monitor: a rising busy marks the first cycle of a frame.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && busy === 1'b1 && prev_busy !== 1'b1) check_frame();
      prev_busy = busy;
    end
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input int unsigned ps);
    exp_t e;
    @(negedge clk);
    P_DATA = d;
    PAR_EN = pe;
    PAR_TYP = pt;
    prescale = PW'(ps);
    DATA_VALID = 1'b1;
    e.data = d;
    e.pe = pe;
    e.pt = pt;
    e.ps = ps;
    exp_q.push_back(e);
    @(negedge clk);
    DATA_VALID = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    logic ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) begin
        P_DATA = 8'h55;
        DATA_VALID = 1'b1;
      end
      if (i == 3) DATA_VALID = 1'b0;
      if (TX_OUT !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL reset_hold: got tx=%b busy=%b, expected tx=1 busy=0", TX_OUT, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (TX_OUT !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL reset_release_idle: got tx=%b busy=%b, expected tx=1 busy=0", TX_OUT, busy);
    end
    n_checks++;
    if (frames_done !== 0) begin
      n_fail++;
      $display("FAIL reset_no_frame: got %0d frames, expected 0", frames_done);
    end
  endtask

  task automatic test_odd_parity();
    int base = frames_done;
    send(8'h09, 1'b1, 1'b1, 8);
    wait_frames(base + 1, 200);
    n_checks++;
    if (frames_done !== base + 1) begin
      n_fail++;
      $display("FAIL odd_frame_count: got %0d, expected %0d", frames_done, base + 1);
    end
    n_checks++;
    if (last_len !== 88) begin
      n_fail++;
      $display("FAIL odd_frame_len: got %0d, expected 88", last_len);
    end
  endtask

  task automatic test_even_and_no_parity();
    int base = frames_done;
    send(8'hA5, 1'b1, 1'b0, 16);
    wait_frames(base + 1, 400);
    n_checks++;
    if (frames_done !== base + 1 || last_len !== 176) begin
      n_fail++;
      $display("FAIL even_frame: got frames=%0d len=%0d, expected frames=%0d len=176",
               frames_done, last_len, base + 1);
    end
    send(8'hA5, 1'b0, 1'b0, 16);
    wait_frames(base + 2, 400);
    n_checks++;
    if (frames_done !== base + 2 || last_len !== 160) begin
      n_fail++;
      $display("FAIL nopar_frame: got frames=%0d len=%0d, expected frames=%0d len=160",
               frames_done, last_len, base + 2);
    end
  endtask

  task automatic test_prescale_zero();
    int base = frames_done;
    send(8'h5A, 1'b1, 1'b1, 0);
    wait_frames(base + 1, 100);
    n_checks++;
    if (frames_done !== base + 1 || last_len !== 11) begin
      n_fail++;
      $display("FAIL prescale_zero: got frames=%0d len=%0d, expected frames=%0d len=11",
               frames_done, last_len, base + 1);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   base = frames_done;
    int   n = 0;
    send(8'hC3, 1'b0, 1'b0, 8);
    repeat (20) @(negedge clk);
    P_DATA = 8'hFF;
    PAR_EN = 1'b1;
    PAR_TYP = 1'b1;
    prescale = PW'(3);
    DATA_VALID = 1'b1;
    @(negedge clk);
    DATA_VALID = 1'b0;
    P_DATA = 8'h81;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    prescale = PW'(8);
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    DATA_VALID = 1'b1;
    e.data = 8'h81;
    e.pe = 1'b0;
    e.pt = 1'b0;
    e.ps = 8;
    exp_q.push_back(e);
    @(negedge clk);
    DATA_VALID = 1'b0;
    wait_frames(base + 2, 300);
    n_checks++;
    if (frames_done !== base + 2) begin
      n_fail++;
      $display("FAIL b2b_frame_count: got %0d, expected %0d", frames_done, base + 2);
    end
    n_checks++;
    if (last_gap !== 1) begin
      n_fail++;
      $display("FAIL b2b_idle_gap: got %0d idle cycles, expected 1", last_gap);
    end
    n_checks++;
    if (last_len !== 80) begin
      n_fail++;
      $display("FAIL b2b_frame_len: got %0d, expected 80", last_len);
    end
  endtask

  task automatic test_reset_mid_frame();
    int   base = frames_done;
    logic ok = 1'b1;
    send(8'hA5, 1'b1, 1'b0, 8);
    repeat (34) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || TX_OUT !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_frame_bit4: got tx=%b busy=%b, expected tx=0 busy=1", TX_OUT, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || TX_OUT !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got tx=%b busy=%b, expected tx=1 busy=0", TX_OUT, busy);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (busy !== 1'b0 || TX_OUT !== 1'b1) ok = 1'b0;
    end
    n_checks++;
    if (!ok || frames_done !== base) begin
      n_fail++;
      $display("FAIL no_resume: got ok=%b frames=%0d, expected ok=1 frames=%0d", ok, frames_done, base);
    end
    send(8'h3C, 1'b1, 1'b1, 8);
    wait_frames(base + 1, 200);
    n_checks++;
    if (frames_done !== base + 1 || last_len !== 88) begin
      n_fail++;
      $display("FAIL post_reset_frame: got frames=%0d len=%0d, expected frames=%0d len=88",
               frames_done, last_len, base + 1);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] d  [0:2];
    logic       pe [0:2];
    logic       pt [0:2];
    d[0] = 8'h09; pe[0] = 1'b1; pt[0] = 1'b1;
    d[1] = 8'h09; pe[1] = 1'b1; pt[1] = 1'b0;
    d[2] = 8'hFF; pe[2] = 1'b0; pt[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      int base = frames_done;
      send(d[k], pe[k], pt[k], 8);
      wait_frames(base + 1, 200);
      n_checks++;
      if (frames_done !== base + 1 || last_rx !== d[k]) begin
        n_fail++;
        $display("FAIL loopback%0d_byte: got %h (frames=%0d), expected %h (frames=%0d)",
                 k, last_rx, frames_done, d[k], base + 1);
      end
      n_checks++;
      if (last_par_err !== 1'b0 || last_stp_err !== 1'b0) begin
        n_fail++;
        $display("FAIL loopback%0d_err: got par_err=%b stp_err=%b, expected 0 0",
                 k, last_par_err, last_stp_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_odd_parity();
    test_even_and_no_parity();
    test_prescale_zero();
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback();
    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
